fu_exec_writeback: RTL and testbench

- Responder end of the reservation-station dispatch interface.
- Accepts one dispatched operation per cycle from the add or mul reservation station and computes its result.
- Add/sub/branch-compare use a 1-stage path; mul/div use a multi-cycle unit.
- Broadcasts each result on a single common data bus (CDB) with ROB index, destination register and RS slot, so the ROB can capture the result and the RS can free the slot.

---
 rtl/fu_exec_writeback.sv | 185 ++++++++++++++++++
 tb/tb_fu_exec_writeback.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_exec_writeback.sv
// fu_exec_writeback: execute/writeback stage behind the add and mul reservation stations.
// A one-stage add path and a multi-cycle mul/div unit share a single registered CDB broadcast.
module fu_exec_writeback #(
    parameter int DATA_W  = 16,
    parameter int MUL_LAT = 3
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              disp_valid,
    input  logic [3:0]        disp_func,
    input  logic [DATA_W-1:0] disp_rs1data,
    input  logic [DATA_W-1:0] disp_rs2data,
    input  logic [2:0]        disp_rob_ind,
    input  logic [3:0]        disp_rd,
    input  logic [1:0]        disp_rsindex,
    output logic              add_ready,
    output logic              mul_ready,
    output logic              cdb_valid,
    output logic [DATA_W-1:0] cdb_data,
    output logic [2:0]        cdb_rob_ind,
    output logic [3:0]        cdb_rd,
    output logic [1:0]        cdb_rsindex,
    output logic              cdb_unit,
    output logic              bad_func
);

    localparam logic [3:0] FUNC_ADD = 4'b0000;
    localparam logic [3:0] FUNC_SUB = 4'b0001;
    localparam logic [3:0] FUNC_MUL = 4'b0010;
    localparam logic [3:0] FUNC_DIV = 4'b0011;
    localparam logic [3:0] FUNC_BEQ = 4'b0110;
    localparam logic [3:0] FUNC_BNE = 4'b0111;
    localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

    typedef enum logic {MUL_IDLE, MUL_BUSY} mul_state_t;

    mul_state_t        mul_state;
    logic [3:0]        mul_cnt;
    logic              mul_done_next;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic              mul_is_div;
    logic [2:0]        mul_rob_ind;
    logic [3:0]        mul_rd;
    logic [1:0]        mul_rsindex;
    logic [DATA_W-1:0] mul_result;

    logic              add_valid;
    logic [DATA_W-1:0] add_data;
    logic [2:0]        add_rob_ind;
    logic [3:0]        add_rd;
    logic [1:0]        add_rsindex;
    logic [DATA_W-1:0] add_result;

    logic              is_add_class;
    logic              is_mul_class;
    logic              is_illegal;
    logic              add_accept;
    logic              mul_accept;

    always_comb begin
        is_add_class = 1'b0;
        is_mul_class = 1'b0;
        case (disp_func)
            FUNC_ADD, FUNC_SUB, FUNC_BEQ, FUNC_BNE: is_add_class = 1'b1;
            FUNC_MUL, FUNC_DIV:                     is_mul_class = 1'b1;
            default: ;
        endcase
        is_illegal = !is_add_class && !is_mul_class;
    end

    // The add entry is only blocked when a mul completion takes the CDB this cycle.
    assign add_ready  = !(add_valid && mul_done_next);
    assign mul_ready  = (mul_state == MUL_IDLE);
    assign add_accept = disp_valid && is_add_class && add_ready;
    assign mul_accept = disp_valid && is_mul_class && mul_ready;

    always_comb begin
        add_result = '0;
        case (disp_func)
            FUNC_ADD: add_result = disp_rs1data + disp_rs2data;
            FUNC_SUB: add_result = disp_rs1data - disp_rs2data;
            FUNC_BEQ: add_result[0] = (disp_rs1data == disp_rs2data);
            FUNC_BNE: add_result[0] = (disp_rs1data != disp_rs2data);
            default: ;
        endcase
    end

    always_comb begin
        mul_result = mul_a * mul_b;
        if (mul_is_div) begin
            mul_result = (mul_b == '0) ? '1 : mul_a / mul_b;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            add_valid   <= 1'b0;
            add_data    <= '0;
            add_rob_ind <= '0;
            add_rd      <= '0;
            add_rsindex <= '0;
        end else if (add_accept) begin
            add_valid   <= 1'b1;
            add_data    <= add_result;
            add_rob_ind <= disp_rob_ind;
            add_rd      <= disp_rd;
            add_rsindex <= disp_rsindex;
        end else if (add_valid && !mul_done_next) begin
            add_valid <= 1'b0;
        end
    end

    // mul_done_next flags the final BUSY cycle so the CDB mux needs no counter compare.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            mul_state     <= MUL_IDLE;
            mul_cnt       <= '0;
            mul_done_next <= 1'b0;
            mul_a         <= '0;
            mul_b         <= '0;
            mul_is_div    <= 1'b0;
            mul_rob_ind   <= '0;
            mul_rd        <= '0;
            mul_rsindex   <= '0;
        end else begin
            case (mul_state)
                MUL_IDLE: begin
                    if (mul_accept) begin
                        mul_state   <= MUL_BUSY;
                        mul_cnt     <= MUL_INIT;
                        mul_a       <= disp_rs1data;
                        mul_b       <= disp_rs2data;
                        mul_is_div  <= (disp_func == FUNC_DIV);
                        mul_rob_ind <= disp_rob_ind;
                        mul_rd      <= disp_rd;
                        mul_rsindex <= disp_rsindex;
                    end
                end
                MUL_BUSY: begin
                    if (mul_cnt == 4'd0) begin
                        mul_state     <= MUL_IDLE;
                        mul_done_next <= 1'b0;
                    end else begin
                        mul_cnt       <= mul_cnt - 4'd1;
                        mul_done_next <= (mul_cnt == 4'd1);
                    end
                end
                default: mul_state <= MUL_IDLE;
            endcase
        end
    end

    // Mul completion wins the CDB; idle cycles leave the payload fields untouched.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            cdb_valid   <= 1'b0;
            cdb_data    <= '0;
            cdb_rob_ind <= '0;
            cdb_rd      <= '0;
            cdb_rsindex <= '0;
            cdb_unit    <= 1'b0;
            bad_func    <= 1'b0;
        end else begin
            cdb_valid <= 1'b0;
            bad_func  <= disp_valid && is_illegal;
            if (mul_done_next) begin
                cdb_valid   <= 1'b1;
                cdb_data    <= mul_result;
                cdb_rob_ind <= mul_rob_ind;
                cdb_rd      <= mul_rd;
                cdb_rsindex <= mul_rsindex;
                cdb_unit    <= 1'b1;
            end else if (add_valid) begin
                cdb_valid   <= 1'b1;
                cdb_data    <= add_data;
                cdb_rob_ind <= add_rob_ind;
                cdb_rd      <= add_rd;
                cdb_rsindex <= add_rsindex;
                cdb_unit    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fu_exec_writeback.sv
// Randomized bench for fu_exec_writeback: an edge-indexed schedule of expected CDB/bad_func
// events is built from the arithmetic and latency rules and compared every cycle.
module tb_fu_exec_writeback;

    localparam int DATA_W  = 16;
    localparam int MUL_LAT = 3;
    localparam int MAX_E   = 6000;

    typedef struct {
        int          gap;
        bit          do_rst;
        logic [3:0]  func;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  rob;
        logic [3:0]  rd;
        logic [1:0]  rs;
    } op_t;

    logic              clk1;
    logic              rst;
    logic              disp_valid;
    logic [3:0]        disp_func;
    logic [DATA_W-1:0] disp_rs1data;
    logic [DATA_W-1:0] disp_rs2data;
    logic [2:0]        disp_rob_ind;
    logic [3:0]        disp_rd;
    logic [1:0]        disp_rsindex;
    logic              add_ready;
    logic              mul_ready;
    logic              cdb_valid;
    logic [DATA_W-1:0] cdb_data;
    logic [2:0]        cdb_rob_ind;
    logic [3:0]        cdb_rd;
    logic [1:0]        cdb_rsindex;
    logic              cdb_unit;
    logic              bad_func;

    fu_exec_writeback #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
        .clk1(clk1), .rst(rst),
        .disp_valid(disp_valid), .disp_func(disp_func),
        .disp_rs1data(disp_rs1data), .disp_rs2data(disp_rs2data),
        .disp_rob_ind(disp_rob_ind), .disp_rd(disp_rd), .disp_rsindex(disp_rsindex),
        .add_ready(add_ready), .mul_ready(mul_ready),
        .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_rob_ind(cdb_rob_ind),
        .cdb_rd(cdb_rd), .cdb_rsindex(cdb_rsindex), .cdb_unit(cdb_unit),
        .bad_func(bad_func)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int n_compared = 0;
    int n_mismatch = 0;

    bit          exp_v    [MAX_E];
    logic [15:0] exp_data [MAX_E];
    logic [2:0]  exp_rob  [MAX_E];
    logic [3:0]  exp_rd   [MAX_E];
    logic [1:0]  exp_rs   [MAX_E];
    bit          exp_unit [MAX_E];
    bit          exp_bad  [MAX_E];

    int          edge_num;
    int          last_add_bcast;
    int          last_mul_done;
    int          max_sched;
    logic [15:0] last_data;
    logic [2:0]  last_rob;
    logic [3:0]  last_rd;
    logic [1:0]  last_rs;

    op_t dir_q[$];
    op_t pend_op;
    bit  pend_valid;
    int  pend_delay;
    int  rand_left;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_num);
        end
    endtask

    task automatic applyStimulus(input op_t o);
        disp_valid   = 1'b1;
        disp_func    = o.func;
        disp_rs1data = o.a;
        disp_rs2data = o.b;
        disp_rob_ind = o.rob;
        disp_rd      = o.rd;
        disp_rsindex = o.rs;
    endtask

    function automatic logic [15:0] ref_result(input logic [3:0] f, input logic [15:0] a,
                                               input logic [15:0] b);
        int unsigned ua = a;
        int unsigned ub = b;
        int unsigned r  = 0;
        case (f)
            4'd0: r = ua + ub;
            4'd1: r = ua - ub;
            4'd2: r = ua * ub;
            4'd3: r = (ub == 0) ? 32'hFFFF : ua / ub;
            4'd6: r = (ua == ub) ? 1 : 0;
            4'd7: r = (ua != ub) ? 1 : 0;
            default: r = 0;
        endcase
        return 16'(r);
    endfunction

    function automatic bit is_add_f(input logic [3:0] f);
        return (f == 4'd0) || (f == 4'd1) || (f == 4'd6) || (f == 4'd7);
    endfunction

    function automatic bit is_mul_f(input logic [3:0] f);
        return (f == 4'd2) || (f == 4'd3);
    endfunction

    function automatic op_t mk(input int gap, input bit r, input logic [3:0] f, input int a,
                               input int b, input int rob, input int rd, input int rs);
        op_t o;
        o.gap = gap; o.do_rst = r; o.func = f;
        o.a = 16'(a); o.b = 16'(b);
        o.rob = 3'(rob); o.rd = 4'(rd); o.rs = 2'(rs);
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        logic [3:0] legal [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7};
        if ($urandom_range(0, 9) == 0)
            o.func = ($urandom_range(0, 1) == 0) ? 4'(4 + $urandom_range(0, 1))
                                                 : 4'($urandom_range(8, 15));
        else
            o.func = legal[$urandom_range(0, 5)];
        o.a = 16'($urandom);
        o.b = 16'($urandom);
        case ($urandom_range(0, 3))
            0: ;
            1: begin o.a = 16'($urandom_range(0, 15)); o.b = 16'($urandom_range(0, 15)); end
            2: o.b = o.a;
            default: o.b = 16'd0;
        endcase
        o.rob    = 3'($urandom);
        o.rd     = 4'($urandom);
        o.rs     = 2'($urandom_range(0, 2));
        o.gap    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
        o.do_rst = ($urandom_range(0, 99) == 0);
        return o;
    endfunction

    task automatic checkReset(input string tag);
        checkOutput({tag, "_cdb_valid"}, 32'(cdb_valid), 32'd0);
        checkOutput({tag, "_cdb_data"}, 32'(cdb_data), 32'd0);
        checkOutput({tag, "_cdb_rob"}, 32'(cdb_rob_ind), 32'd0);
        checkOutput({tag, "_cdb_rd"}, 32'(cdb_rd), 32'd0);
        checkOutput({tag, "_cdb_rs"}, 32'(cdb_rsindex), 32'd0);
        checkOutput({tag, "_cdb_unit"}, 32'(cdb_unit), 32'd0);
        checkOutput({tag, "_bad_func"}, 32'(bad_func), 32'd0);
        checkOutput({tag, "_add_ready"}, 32'(add_ready), 32'd1);
        checkOutput({tag, "_mul_ready"}, 32'(mul_ready), 32'd1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < MAX_E; i++) begin
            exp_v[i] = 1'b0;
            exp_bad[i] = 1'b0;
        end
        last_add_bcast = 0;
        last_mul_done  = 0;
        last_data = '0; last_rob = '0; last_rd = '0; last_rs = '0;
    endtask

    // Reset asserted between edges; everything in flight must vanish without a broadcast.
    task automatic do_reset();
        rst = 1'b1;
        disp_valid = 1'b0;
        #1;
        checkReset("mid_rst");
        repeat (2) begin
            @(posedge clk1);
            edge_num++;
        end
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic check_edge(input int e);
        if (exp_v[e]) begin
            checkOutput("cdb_valid", 32'(cdb_valid), 32'd1);
            checkOutput("cdb_data", 32'(cdb_data), 32'(exp_data[e]));
            checkOutput("cdb_rob", 32'(cdb_rob_ind), 32'(exp_rob[e]));
            checkOutput("cdb_rd", 32'(cdb_rd), 32'(exp_rd[e]));
            checkOutput("cdb_rs", 32'(cdb_rsindex), 32'(exp_rs[e]));
            checkOutput("cdb_unit", 32'(cdb_unit), 32'(exp_unit[e]));
            last_data = exp_data[e]; last_rob = exp_rob[e];
            last_rd = exp_rd[e]; last_rs = exp_rs[e];
        end else begin
            checkOutput("cdb_idle", 32'(cdb_valid), 32'd0);
            checkOutput("hold_data", 32'(cdb_data), 32'(last_data));
            checkOutput("hold_rob", 32'(cdb_rob_ind), 32'(last_rob));
            checkOutput("hold_rd", 32'(cdb_rd), 32'(last_rd));
            checkOutput("hold_rs", 32'(cdb_rsindex), 32'(last_rs));
        end
        checkOutput("bad_func", 32'(bad_func), 32'(exp_bad[e]));
    endtask

    task automatic schedule(input int e, input op_t o, input bit unit);
        if (exp_v[e]) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL cdb_slot_clash: edge %0d already booked, required free", e);
        end
        exp_v[e] = 1'b1;
        exp_data[e] = ref_result(o.func, o.a, o.b);
        exp_rob[e] = o.rob;
        exp_rd[e] = o.rd;
        exp_rs[e] = o.rs;
        exp_unit[e] = unit;
        if (e > max_sched) max_sched = e;
    endtask

    initial begin
        int  n;
        bit  add_rdy_m;
        bit  mul_rdy_m;
        bit  done;
        int  slot;

        rst = 1'b1;
        disp_valid = 1'b0;
        disp_func = '0; disp_rs1data = '0; disp_rs2data = '0;
        disp_rob_ind = '0; disp_rd = '0; disp_rsindex = '0;
        edge_num = 0;
        max_sched = 0;
        pend_valid = 1'b0;
        pend_delay = 0;
        rand_left = 300;
        clear_model();

        dir_q.push_back(mk(0, 0, 4'd0, 5, 7, 2, 3, 1));
        dir_q.push_back(mk(2, 0, 4'd1, 3, 5, 1, 4, 0));
        dir_q.push_back(mk(2, 0, 4'd3, 9, 0, 3, 5, 2));
        dir_q.push_back(mk(4, 0, 4'd2, 300, 300, 4, 6, 0));
        dir_q.push_back(mk(4, 0, 4'd6, 4, 4, 5, 7, 1));
        dir_q.push_back(mk(1, 0, 4'd7, 4, 4, 6, 8, 2));
        dir_q.push_back(mk(3, 0, 4'd2, 10, 20, 7, 9, 0));
        dir_q.push_back(mk(0, 0, 4'd2, 7, 8, 0, 10, 1));
        dir_q.push_back(mk(6, 0, 4'd2, 100, 3, 1, 11, 2));
        dir_q.push_back(mk(1, 0, 4'd0, 1, 1, 2, 12, 0));
        dir_q.push_back(mk(6, 0, 4'd4, 1, 2, 3, 13, 1));
        dir_q.push_back(mk(0, 0, 4'd0, 2, 3, 4, 14, 2));
        dir_q.push_back(mk(6, 0, 4'd2, 50, 60, 5, 15, 0));
        dir_q.push_back(mk(0, 0, 4'd0, 9, 9, 6, 1, 1));
        dir_q.push_back(mk(0, 1, 4'd0, 1, 2, 7, 2, 2));
        dir_q.push_back(mk(0, 0, 4'd3, 60, 7, 0, 3, 0));

        #3;
        checkReset("reset");
        @(posedge clk1);
        edge_num = 1;
        #1;
        rst = 1'b0;

        done = 1'b0;
        while (!done) begin
            if (!pend_valid) begin
                if (dir_q.size() > 0) begin
                    pend_op = dir_q.pop_front();
                    pend_valid = 1'b1;
                end else if (rand_left > 0) begin
                    pend_op = rand_op();
                    rand_left--;
                    pend_valid = 1'b1;
                end
                if (pend_valid) begin
                    pend_delay = pend_op.gap;
                    if (pend_op.do_rst) do_reset();
                end
            end

            n = edge_num + 1;
            mul_rdy_m = (n > last_mul_done);
            add_rdy_m = !(exp_v[n] && exp_unit[n] && (last_add_bcast > n));
            checkOutput("add_ready", 32'(add_ready), 32'(add_rdy_m));
            checkOutput("mul_ready", 32'(mul_ready), 32'(mul_rdy_m));

            if (pend_valid && pend_delay == 0) begin
                applyStimulus(pend_op);
                if (!is_add_f(pend_op.func) && !is_mul_f(pend_op.func)) begin
                    exp_bad[n] = 1'b1;
                    if (n > max_sched) max_sched = n;
                    pend_valid = 1'b0;
                end else if (is_add_f(pend_op.func) && add_rdy_m) begin
                    slot = (exp_v[n+1] && exp_unit[n+1]) ? n + 2 : n + 1;
                    schedule(slot, pend_op, 1'b0);
                    last_add_bcast = slot;
                    pend_valid = 1'b0;
                end else if (is_mul_f(pend_op.func) && mul_rdy_m) begin
                    slot = n + MUL_LAT;
                    schedule(slot, pend_op, 1'b1);
                    last_mul_done = slot;
                    pend_valid = 1'b0;
                end
            end else begin
                disp_valid = 1'b0;
                if (pend_valid) pend_delay--;
            end

            @(posedge clk1);
            edge_num++;
            #1;
            check_edge(edge_num);

            if (!pend_valid && dir_q.size() == 0 && rand_left == 0 && edge_num > max_sched)
                done = 1'b1;
            if (edge_num > MAX_E - 20) begin
                n_compared++;
                n_mismatch++;
                $display("[TB] FAIL timeout: reached edge %0d, required drain before %0d",
                         edge_num, MAX_E - 20);
                done = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
